// File: rtl/br_pred_gshare_if.sv
// br_pred_gshare_if - fetch/retire signal bundle for the gshare predictor.
//
// Parameters:
//   ADDR  PC width
//
// Signals:
//   flush_         pipeline flush, active low
//   br_pc          PC of the branch being predicted
//   br_req_        prediction request, active low
//   br_pred        predicted direction, 1 = taken (driven by the predictor)
//   commit_pc      PC of the retiring branch
//   br_commit_     branch commit strobe, active low
//   br_result      resolved direction, 1 = taken
//   br_pred_miss_  mispredict flag, active low, qualified by br_commit_
//
// Modports:
//   master  fetch/retire side, drives everything except br_pred
//   slave   predictor side
interface br_pred_gshare_if #(
  parameter int ADDR = 32
);
  logic            flush_;
  logic [ADDR-1:0] br_pc;
  logic            br_req_;
  logic            br_pred;
  logic [ADDR-1:0] commit_pc;
  logic            br_commit_;
  logic            br_result;
  logic            br_pred_miss_;

  modport master (
    output flush_, br_pc, br_req_, commit_pc, br_commit_, br_result, br_pred_miss_,
    input  br_pred
  );

  modport slave (
    input  flush_, br_pc, br_req_, commit_pc, br_commit_, br_result, br_pred_miss_,
    output br_pred
  );
endinterface

// File: rtl/br_pred_gshare.sv
// br_pred_gshare - gshare branch direction predictor.
//
// A table of DEPTH saturating counters indexed by PC bits XOR a global
// history register. Two histories are kept: a speculative one shifted with
// each prediction, and a committed one shifted with each retired branch and
// used to repair the speculative one on mispredict or flush.
//
// Build option:
//   GSHARE_HIST_EN  when defined, history is used (gshare); when undefined
//                   the histories are removed and the table is indexed by PC
//                   bits only (bimodal). flush_, br_req_ and br_pred_miss_
//                   then have no effect.
//
// Parameters:
//   ADDR   PC width
//   CNT    counter width (>= 2)
//   DEPTH  number of counters, power of two
//   HIST   history width, 1 <= HIST <= log2(DEPTH)
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    br_pred_gshare_if.slave: prediction request/response and
//          commit feedback
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef PredCntWidth
`define PredCntWidth 2
`endif
`ifndef PredTableDepth
`define PredTableDepth 16
`endif
`ifndef PredHistWidth
`define PredHistWidth 4
`endif
`ifndef InstWidth
`define InstWidth 32
`endif
`ifndef ByteBitWidth
`define ByteBitWidth 8
`endif

module br_pred_gshare #(
  parameter int ADDR  = `AddrWidth,
  parameter int CNT   = `PredCntWidth,
  parameter int DEPTH = `PredTableDepth,
  parameter int HIST  = `PredHistWidth
) (
  input  logic clk,
  input  logic reset,
  br_pred_gshare_if.slave bus
);

  localparam int PTR = $clog2(DEPTH);
  localparam int OFS = $clog2(`InstWidth / `ByteBitWidth);

  // Weakly taken: MSB set, all lower bits clear.
  localparam logic [CNT-1:0] CNT_INIT = {1'b1, {(CNT-1){1'b0}}};
  localparam logic [CNT-1:0] CNT_MAX  = {CNT{1'b1}};

  logic [CNT-1:0] cnt_tbl [DEPTH];
  logic [PTR-1:0] pred_idx;
  logic [PTR-1:0] com_idx;
  logic [CNT-1:0] cnt_cur;
  logic [CNT-1:0] cnt_upd;
  logic           pred;

  // Keeps the PC bits outside the index field from being flagged as unused.
  logic unused_bits;

`ifdef GSHARE_HIST_EN
  logic [HIST-1:0] spec_ghr;
  logic [HIST-1:0] spec_ghr_nxt;
  logic [HIST-1:0] com_ghr;
  logic [HIST-1:0] com_ghr_nxt;

  // Shift a new outcome in at the LSB; the truncating cast also covers HIST = 1.
  function automatic logic [HIST-1:0] shift_in(input logic [HIST-1:0] ghr, input logic b);
    return HIST'({ghr, b});
  endfunction

  always_comb begin
    com_ghr_nxt = com_ghr;
    if (!bus.br_commit_) com_ghr_nxt = shift_in(com_ghr, bus.br_result);

    // Repair sources take the history including this cycle's commit, so a
    // same-cycle request is wrong-path and its shift is dropped.
    spec_ghr_nxt = spec_ghr;
    if (!bus.br_commit_ && !bus.br_pred_miss_) spec_ghr_nxt = com_ghr_nxt;
    else if (!bus.flush_)                      spec_ghr_nxt = com_ghr_nxt;
    else if (!bus.br_req_)                     spec_ghr_nxt = shift_in(spec_ghr, pred);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_ghr <= '0;
      com_ghr  <= '0;
    end else begin
      spec_ghr <= spec_ghr_nxt;
      com_ghr  <= com_ghr_nxt;
    end
  end

  assign pred_idx    = bus.br_pc[PTR+OFS-1:OFS] ^ PTR'(spec_ghr);
  assign com_idx     = bus.commit_pc[PTR+OFS-1:OFS] ^ PTR'(com_ghr);
  assign unused_bits = ^{bus.br_pc, bus.commit_pc};
`else
  assign pred_idx    = bus.br_pc[PTR+OFS-1:OFS];
  assign com_idx     = bus.commit_pc[PTR+OFS-1:OFS];
  assign unused_bits = ^{bus.br_pc, bus.commit_pc, bus.flush_, bus.br_req_, bus.br_pred_miss_};
`endif

  // No bypass: a same-cycle commit to pred_idx is seen from the next cycle.
  assign pred        = cnt_tbl[pred_idx][CNT-1];
  assign bus.br_pred = pred;

  assign cnt_cur = cnt_tbl[com_idx];

  always_comb begin
    cnt_upd = cnt_cur;
    if (bus.br_result) begin
      if (cnt_cur != CNT_MAX) cnt_upd = cnt_cur + CNT'(1);
    end else begin
      if (cnt_cur != '0) cnt_upd = cnt_cur - CNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_tbl[i] <= CNT_INIT;
    end else if (!bus.br_commit_) begin
      cnt_tbl[com_idx] <= cnt_upd;
    end
  end

endmodule

// File: doc/br_pred_gshare.md
# br_pred_gshare

Parametrised gshare direction predictor, the successor of the PC-indexed saturating-counter table. It indexes a table of saturating counters with the branch PC XOR a global history register (GHR) and keeps two GHRs. The speculative GHR is shifted on every prediction request. The committed GHR is shifted on every branch commit and is copied into the speculative GHR on a misprediction or pipeline flush. It sits in the fetch stage, with the commit path fed back from retirement.

## Interface
Parameters:
- ADDR, `AddrWidth, PC width.
- CNT, `PredCntWidth, counter width, ≥2.
- DEPTH, `PredTableDepth, number of counters, power of two; PTR = log2(DEPTH).
- HIST, `PredHistWidth, GHR width, 1 ≤ HIST ≤ PTR.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- flush_  in  1  active-low pipeline flush: copy the committed GHR into the speculative GHR.
- br_pc  in  ADDR  PC of the branch being predicted.
- br_req_  in  1  active-low prediction request: shift the speculative GHR with br_pred.
- br_pred  out  1  prediction, 1 = taken; combinational from br_pc and current state.
- commit_pc  in  ADDR  PC of the retiring branch.
- br_commit_  in  1  active-low branch-commit strobe.
- br_result  in  1  resolved direction, 1 = taken.
- br_pred_miss_  in  1  active-low mispredict flag; qualified by br_commit_.

## Operation
- OFS = log2(`InstWidth/`ByteBitWidth).
- Prediction index = br_pc[PTR+OFS-1:OFS] XOR zero-extended spec_ghr.
- Commit index = commit_pc[PTR+OFS-1:OFS] XOR zero-extended com_ghr. Because branches commit in order and every mispredict repairs spec_ghr, this equals the index used at prediction.
- br_pred = MSB of the indexed counter.
- Counter update, on br_commit_ = 0 only:
  - taken: counter + 1, saturating at 2^CNT-1.
  - not taken: counter − 1, saturating at 0.
  - Only the counter at the commit index changes.
- GHR shift rule: ghr_next = {ghr[HIST-2:0], bit}. For HIST = 1, ghr_next = bit.
- com_ghr: shifted with br_result on every commit.
- spec_ghr next value, in priority order:
  1. reset → 0.
  2. Commit with br_pred_miss_ = 0 → shifted com_ghr, i.e. including the current br_result.
  3. flush_ = 0 → com_ghr, or shifted com_ghr if a commit without mispredict occurs in the same cycle.
  4. br_req_ = 0 → spec_ghr shifted with br_pred.
  5. Otherwise hold.
- A mispredict or flush in the same cycle as br_req_ drops the request's history shift, because the request is wrong-path. br_pred is still driven.
- br_pred_miss_ is ignored when br_commit_ = 1.
- Commit and prediction at the same index in the same cycle: br_pred uses the pre-update counter. There is no bypass.

## Timing
- Reset values: all counters = 2^(CNT-1) (weakly taken); spec_ghr = com_ghr = 0. br_pred is therefore 1 for every PC from the first cycle after reset.
- Reset asserted mid-operation overrides every commit, flush and request in that cycle.
- Prediction latency: 0 cycles (same-cycle combinational).
- Updates are visible to br_pred from the cycle after the strobe.
- After a mispredict at edge N, a prediction in cycle N+1 uses the repaired history.
- No handshake or back-pressure: one request and one commit per cycle, both always accepted.

## Configuration
- GSHARE_HIST_EN defined: behaviour as above.
- GSHARE_HIST_EN undefined:
  - Both GHRs are removed; the index is the PC bits only (bimodal).
  - flush_, br_req_ and br_pred_miss_ are accepted but have no effect.
  - Counter update and reset behaviour are unchanged.

## Test plan
For all scenarios: CNT = 2, DEPTH = 16, HIST = 4, OFS = 2; GSHARE_HIST_EN defined unless stated.
- Reset: assert reset for 1 cycle, then sweep br_pc 0x00–0x3C → br_pred = 1 for every PC; com_ghr = 0.
- Saturation: 3 commits not-taken at commit_pc 0x10 with history held at 0 → counter 2→1→0→0; br_pred at 0x10 = 0. Then 4 taken commits → counter saturates at 3.
- Speculative shift: br_req_ low for 3 cycles with predictions 1, 1, 0 → spec_ghr = 4'b0110; br_pc 0x04 then indexes entry 1 XOR 6 = 7.
- Mispredict repair:
  - Setup: com_ghr = 4'b0001, spec_ghr = 4'b1011.
  - Stimulus: commit with br_result = 0 and br_pred_miss_ = 0, plus br_req_ = 0 in the same cycle.
  - Expected next cycle: spec_ghr = com_ghr = 4'b0010.
- Same-index collision: commit taken and predict at the same index with counter = 1 → br_pred = 0 that cycle and 1 the next.
- Flush while a commit without mispredict is in flight (com_ghr = 4'b0011, br_result = 1) → spec_ghr = 4'b0111. Rebuild with GSHARE_HIST_EN undefined → entry 0x14 is addressed as index 5 regardless of history.
